// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch sequencer feeding the UART transmitter; UART_TXQ_TIMEOUT_EN adds a WAIT_DONE watchdog.
// Latency: a write at edge n into an idle, empty queue raises TxEn from edge n+2 for TXEN_CYCLES cycles.
// Backpressure: none upstream; a write while Full with no same-cycle pop is dropped and sets sticky Overflow.
module uart_tx_queue #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TXEN_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                WrEn,
    input  logic [7:0]          WrData,
    input  logic                TxDone,
    output logic [7:0]          TxData,
    output logic                TxEn,
    output logic                Full,
    output logic                Empty,
    output logic [DEPTH_LOG2:0] Count,
    output logic                Busy,
    output logic                Overflow
`ifdef UART_TXQ_TIMEOUT_EN
    ,
    output logic                TimeoutErr
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SCW   = $clog2(TXEN_CYCLES);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // The transmitter's edge detector needs at least two cycles of TxEn.
    if (TXEN_CYCLES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2097151) begin : g_bad_param
        $error("uart_tx_queue: TXEN_CYCLES must be >= 2 and TIMEOUT_CYCLES must fit 21 bits");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STROBE    = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_CLR  = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop;
    logic                  wr_acc;
    logic                  done_meta;
    logic                  done_sync;
    logic [SCW-1:0]        strobe_cnt;
`ifdef UART_TXQ_TIMEOUT_EN
    logic [20:0]           tmo_cnt;
`endif

    assign Full   = (Count == FULL_CNT);
    assign Empty  = (Count == '0);
    assign pop    = (state == LOAD);
    // A pop in the same cycle frees the slot, so a write at Full is still taken.
    assign wr_acc = WrEn && (!Full || pop);

    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !pop) begin
                Count <= Count + 1'b1;
            end else if (pop && !wr_acc) begin
                Count <= Count - 1'b1;
            end
            if (WrEn && !wr_acc) begin
                Overflow <= 1'b1;
            end
        end
    end

    // TxDone comes from the Tick domain.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
        end else begin
            done_meta <= TxDone;
            done_sync <= done_meta;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            TxData     <= '0;
            TxEn       <= 1'b0;
            Busy       <= 1'b0;
            strobe_cnt <= '0;
`ifdef UART_TXQ_TIMEOUT_EN
            tmo_cnt    <= '0;
            TimeoutErr <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (!Empty) begin
                        state <= LOAD;
                        Busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    TxData     <= mem[rd_ptr];
                    TxEn       <= 1'b1;
                    strobe_cnt <= '0;
`ifdef UART_TXQ_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == SCW'(TXEN_CYCLES - 1)) begin
                        TxEn  <= 1'b0;
                        state <= WAIT_DONE;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done_sync) begin
                        state <= WAIT_CLR;
`ifdef UART_TXQ_TIMEOUT_EN
                    end else if (tmo_cnt == 21'(TIMEOUT_CYCLES - 1)) begin
                        TimeoutErr <= 1'b1;
                        state      <= WAIT_CLR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                // Holding here keeps a still-high TxDone from retiring the next byte.
                WAIT_CLR: begin
                    if (!done_sync) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    TxEn  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and launch sequencer placed directly upstream of the UART RS-232 transmitter. It buffers bytes written by the processor-side bus in a synchronous FIFO. It presents one byte at a time on `TxData`, generates the edge-detected `TxEn` strobe, and holds `TxData` stable until the transmitter reports `TxDone`. It then waits for `TxDone` to clear before launching the next byte.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries.
- `TXEN_CYCLES`, 4: `TxEn` high width in Clk cycles; minimum 2, because the transmitter samples `TxEn` through a 2-flop edge detector.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit for the WAIT_DONE state. Used only with `UART_TXQ_TIMEOUT_EN`.
- `Clk` in 1: system clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `WrEn` in 1: write strobe, one byte per cycle.
- `WrData` in 8: byte to enqueue.
- `TxDone` in 1: transmitter done flag, driven from the Tick domain. It passes through a 2-flop synchronizer internally.
- `TxData` out 8: byte to the transmitter.
- `TxEn` out 1: launch strobe to the transmitter.
- `Full` out 1: Count == 2^DEPTH_LOG2.
- `Empty` out 1: Count == 0.
- `Count` out DEPTH_LOG2+1: FIFO occupancy.
- `Busy` out 1: sequencer is not in IDLE.
- `Overflow` out 1: sticky; set when a write is dropped.
- `TimeoutErr` out 1: sticky; only present with `UART_TXQ_TIMEOUT_EN`.

## Operation
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read and write pointers. Pointers wrap modulo the depth.
  - A write is accepted when `WrEn` is high and either !Full or a pop occurs in the same cycle.
  - A write while Full with no pop is dropped and sets `Overflow`. Only reset clears `Overflow`.
  - Write and pop in the same cycle: Count is unchanged and both pointers advance.
- Sequencer states:
  - IDLE: if !Empty, go to LOAD.
  - LOAD: pop, TxData <= mem[rd], rd++, Count--; go to STROBE.
  - STROBE: TxEn = 1 for TXEN_CYCLES cycles; then go to WAIT_DONE.
  - WAIT_DONE: wait for synchronized TxDone == 1; then go to WAIT_CLR.
  - WAIT_CLR: wait for synchronized TxDone == 0; then go to IDLE.
- `TxData` changes only in LOAD. It is stable from STROBE entry until the next LOAD.
- WAIT_CLR is mandatory. It prevents a new launch while the transmitter still holds `TxDone` high.
- `TxEn` is registered and glitch-free. It is high only in STROBE.
- `Busy` = (state != IDLE).
- Reset values:
  - All outputs 0, except Empty = 1.
  - Pointers 0, Count 0, state IDLE, synchronizer flops 0.
- Reset mid-operation: the queue is discarded and `TxEn` drops asynchronously. A byte the transmitter is already sending completes on its own.

## Timing
- Write latency: `WrEn` sampled at edge n gives Count/Empty/Full updated after edge n.
- Launch latency, with an empty queue in IDLE and a write at edge n:
  - LOAD entered at edge n+1.
  - TxData valid and TxEn = 1 at edge n+2.
  - TxEn = 0 at edge n+2+TXEN_CYCLES.
- TxDone response: a rising TxDone is seen by the sequencer 2–3 Clk edges later. The falling edge has the same delay.
- Back-to-back bytes: the next LOAD occurs 1 edge after WAIT_CLR exits.
- Count arithmetic uses DEPTH_LOG2+1 bits and never exceeds 2^DEPTH_LOG2. No increment is allowed at Full; no decrement is allowed at Empty.

## Configuration
- `UART_TXQ_TIMEOUT_EN` defined:
  - A 21-bit cycle counter runs in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, set `TimeoutErr` (sticky until reset) and go to WAIT_CLR. The byte is lost.
- Not defined:
  - No counter is built and `TimeoutErr` is absent.
  - WAIT_DONE waits indefinitely.

## Test plan
- Single byte: write 0xA5 to an idle block -> TxEn high for exactly 4 cycles starting 2 edges after the write. TxData = 0xA5 throughout. Busy stays high until TxDone rises and falls, then returns to IDLE.
- Burst: write 0x01..0x05 on consecutive cycles -> five launches in order. TxData holds each value until its TxDone cycle. No launch occurs while TxDone is high. Count returns to 0.
- Full/overflow, depth 16, sequencer stalled in WAIT_DONE:
  - Write 17 bytes -> Full = 1, Count = 16, Overflow = 1.
  - The 17th byte is never transmitted.
- Write at full during pop: fill to 16 and stall, then release TxDone so LOAD coincides with a write of 0x3C -> write accepted, Count stays 16, Overflow = 0.
- Reset mid-STROBE: assert Rst_n low -> TxEn = 0, Empty = 1, Count = 0 immediately. After release, no TxEn occurs until a new write.
- With `UART_TXQ_TIMEOUT_EN` and TIMEOUT_CYCLES = 100: TxDone held at 0 after a launch -> TimeoutErr = 1 after 100 cycles in WAIT_DONE, then IDLE. The next queued byte launches normally.
